// File: rtl/timer_digit_entry_pkg.sv
// Shared types and constants for the microwave timer keypad entry block.
// Holds the FSM encoding, BCD limits and the MM:SS buffer layout.
package timer_digit_entry_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ENTRY = S_ENTRY,
    LOAD  = S_LOAD,
    RUN   = S_RUN
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [2:0] DIGITS_MAX   = 3'd4;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  // Seconds above 59 clamp to 59; minutes pass through.
  function automatic mmss_t normalise(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_tens > SEC_TENS_MAX) begin
      r.sec_tens = SEC_TENS_MAX;
      r.sec_ones = BCD_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_digit_entry_buffer.sv
// Four-digit BCD shift-in register with digit count and saturation.
// Priority: clear/flush, then parallel load, then shift.
module bcd_shift_buffer
  import timer_digit_entry_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       flush,
  input  logic       load_en,
  input  mmss_t      load_val,
  input  logic       shift_en,
  input  logic [3:0] digit,
  output mmss_t      value,
  output logic [2:0] digit_count
);

  always_ff @(posedge clk) begin
    if (clear || flush) begin
      value       <= '0;
      digit_count <= '0;
    end else if (load_en) begin
      value <= load_val;
    end else if (shift_en && (digit_count < DIGITS_MAX)) begin
      value       <= {value.min_ones, value.sec_tens,
                      value.sec_ones, digit};
      digit_count <= digit_count + 3'd1;
    end
  end

endmodule

// File: rtl/timer_digit_entry.sv
// Keypad-side writer for the MM:SS down-counter chain: buffers digits,
// normalises seconds, strobes the parallel load and tracks the run.
module timer_digit_entry
  import timer_digit_entry_pkg::*;
#(
  parameter logic [3:0] QS_SEC_TENS = 4'd3,
  parameter logic [3:0] QS_SEC_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_key,
  input  logic       cancel_key,
  input  logic       timer_zero,
  output logic       loadn,
  output logic       count_enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       running
);

  localparam mmss_t QS_VAL = {4'd0, 4'd0, QS_SEC_TENS, QS_SEC_ONES};

  state_t state;
  mmss_t  buf_q;
  mmss_t  load_val;
  logic   flush;
  logic   load_en;
  logic   shift_en;
  logic   key_ok;
  logic   buf_zero;

  assign key_ok   = key_valid && (key_code <= BCD_MAX);
  assign buf_zero = (buf_q == '0);

  // cancel > start > key; RUN and LOAD ignore keys and start.
  always_comb begin
    flush    = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    load_val = normalise(buf_q);
    unique case (state)
      IDLE: begin
        if (!cancel_key) begin
          if (start_key) begin
            load_en  = 1'b1;
            load_val = QS_VAL;
          end else begin
            shift_en = key_ok;
          end
        end
      end
      ENTRY: begin
        if (cancel_key) begin
          flush = 1'b1;
        end else if (start_key) begin
          flush   = buf_zero;
          load_en = !buf_zero;
        end else begin
          shift_en = key_ok;
        end
      end
      RUN: flush = cancel_key || timer_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= IDLE;
      loadn        <= 1'b1;
      count_enable <= 1'b0;
      running      <= 1'b0;
    end else begin
      loadn <= 1'b1;
      unique case (state)
        IDLE: begin
          if (load_en) begin
            state <= LOAD;
            loadn <= 1'b0;
          end else if (shift_en) begin
            state <= ENTRY;
          end
        end
        ENTRY: begin
          if (flush) begin
            state <= IDLE;
          end else if (load_en) begin
            state <= LOAD;
            loadn <= 1'b0;
          end
        end
        LOAD: begin
          state        <= RUN;
          count_enable <= 1'b1;
          running      <= 1'b1;
        end
        RUN: begin
          if (flush) begin
            state        <= IDLE;
            count_enable <= 1'b0;
            running      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bcd_shift_buffer u_buf (
    .clk         (clk),
    .clear       (clear),
    .flush       (flush),
    .load_en     (load_en),
    .load_val    (load_val),
    .shift_en    (shift_en),
    .digit       (key_code),
    .value       (buf_q),
    .digit_count (digit_count)
  );

  assign min_tens = buf_q.min_tens;
  assign min_ones = buf_q.min_ones;
  assign sec_tens = buf_q.sec_tens;
  assign sec_ones = buf_q.sec_ones;

endmodule

// File: tb/tb_timer_digit_entry.sv
// Bench for timer_digit_entry: directed scenarios plus a random run
// checked against a decimal-arithmetic model of the keypad timer.
module tb_timer_digit_entry;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start_key = 1'b0;
  logic       cancel_key = 1'b0;
  logic       timer_zero = 1'b0;
  logic       loadn;
  logic       count_enable;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [2:0] digit_count;
  logic       running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_digit_entry dut (
    .clk          (clk),
    .clear        (clear),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .start_key    (start_key),
    .cancel_key   (cancel_key),
    .timer_zero   (timer_zero),
    .loadn        (loadn),
    .count_enable (count_enable),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .digit_count  (digit_count),
    .running      (running)
  );

  logic [21:0] obs;
  assign obs = {loadn, count_enable, running, digit_count,
                min_tens, min_ones, sec_tens, sec_ones};

  function automatic logic [21:0] vec(input logic ln, input logic ce,
                                      input logic rn, input int cnt,
                                      input logic [15:0] d);
    return {ln, ce, rn, 3'(cnt), d};
  endfunction

  // Model: buffer as a decimal number, phase 0 idle/entry, 1 load, 2 run.
  localparam int QS_SECS = 30;
  int m_val = 0;
  int m_cnt = 0;
  int m_phase = 0;
  int m_load = 0;

  function automatic void m_clear();
    m_val = 0;
    m_cnt = 0;
    m_phase = 0;
    m_load = 0;
  endfunction

  function automatic void m_step(input logic c, input logic kv,
                                 input logic [3:0] kc, input logic sk,
                                 input logic ck, input logic tz);
    int mm, ss;
    if (c) begin
      m_clear();
    end else if (m_phase == 0) begin
      if (ck) begin
        m_clear();
      end else if (sk) begin
        if (m_cnt == 0) begin
          m_load = QS_SECS;
          m_phase = 1;
        end else if (m_val == 0) begin
          m_clear();
        end else begin
          mm = m_val / 100;
          ss = m_val % 100;
          if (ss > 59) ss = 59;
          m_load = mm * 100 + ss;
          m_phase = 1;
        end
      end else if (kv && kc <= 4'd9 && m_cnt < 4) begin
        m_val = m_val * 10 + int'(kc);
        m_cnt++;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (ck || tz) begin
      m_clear();
    end
  endfunction

  function automatic logic [21:0] m_expect();
    int s;
    logic [15:0] d;
    s = (m_phase == 0) ? m_val : m_load;
    d = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    return vec(m_phase != 1, m_phase == 2, m_phase == 2, m_cnt, d);
  endfunction

  task automatic tick(input logic c, input logic kv, input logic [3:0] kc,
                      input logic sk, input logic ck, input logic tz);
    clear = c;
    key_valid = kv;
    key_code = kc;
    start_key = sk;
    cancel_key = ck;
    timer_zero = tz;
    m_step(c, kv, kc, sk, ck, tz);
    @(posedge clk);
    #1;
    clear = 1'b0;
    key_valid = 1'b0;
    start_key = 1'b0;
    cancel_key = 1'b0;
    timer_zero = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    tick(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start();
    tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
  endtask

  task automatic test_entry_load();
    logic [3:0]  keys [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
    logic [15:0] want [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1230};
    for (int i = 0; i < 4; i++) begin
      key(keys[i]);
      checks++;
      if (obs !== vec(1, 0, 0, i + 1, want[i])) begin
        errors++;
        $display("FAIL entry_key%0d: got %h want %h", i, obs,
                 vec(1, 0, 0, i + 1, want[i]));
      end
    end
    start();
    checks++;
    if (obs !== vec(0, 0, 0, 4, 16'h1230)) begin
      errors++;
      $display("FAIL entry_loadn: got %h want %h", obs, vec(0, 0, 0, 4, 16'h1230));
    end
    idle();
    checks++;
    if (obs !== vec(1, 1, 1, 4, 16'h1230)) begin
      errors++;
      $display("FAIL entry_run: got %h want %h", obs, vec(1, 1, 1, 4, 16'h1230));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL entry_zero: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
  endtask

  task automatic test_normalise();
    key(4'd9);
    key(4'd9);
    checks++;
    if (obs !== vec(1, 0, 0, 2, 16'h0099)) begin
      errors++;
      $display("FAIL norm_entry: got %h want %h", obs, vec(1, 0, 0, 2, 16'h0099));
    end
    start();
    checks++;
    if (obs !== vec(0, 0, 0, 2, 16'h0059)) begin
      errors++;
      $display("FAIL norm_load: got %h want %h", obs, vec(0, 0, 0, 2, 16'h0059));
    end
    idle();
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL norm_cancel: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
  endtask

  task automatic test_quick_start();
    start();
    checks++;
    if (obs !== vec(0, 0, 0, 0, 16'h0030)) begin
      errors++;
      $display("FAIL qs_load: got %h want %h", obs, vec(0, 0, 0, 0, 16'h0030));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== vec(1, 1, 1, 0, 16'h0030)) begin
      errors++;
      $display("FAIL qs_zero_in_load: got %h want %h", obs, vec(1, 1, 1, 0, 16'h0030));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL qs_zero: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
  endtask

  task automatic test_saturate();
    key(4'd12);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL sat_bad_idle: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
    for (int i = 1; i <= 5; i++) key(4'(i));
    checks++;
    if (obs !== vec(1, 0, 0, 4, 16'h1234)) begin
      errors++;
      $display("FAIL sat_five: got %h want %h", obs, vec(1, 0, 0, 4, 16'h1234));
    end
    key(4'd12);
    checks++;
    if (obs !== vec(1, 0, 0, 4, 16'h1234)) begin
      errors++;
      $display("FAIL sat_bad_code: got %h want %h", obs, vec(1, 0, 0, 4, 16'h1234));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_cancel_zero();
    key(4'd1);
    key(4'd5);
    start();
    idle();
    checks++;
    if (obs !== vec(1, 1, 1, 2, 16'h0015)) begin
      errors++;
      $display("FAIL cz_run: got %h want %h", obs, vec(1, 1, 1, 2, 16'h0015));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL cz_exit: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
    idle();
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL cz_no_reload: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
  endtask

  task automatic test_priority();
    key(4'd1);
    key(4'd2);
    tick(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== vec(0, 0, 0, 2, 16'h0012)) begin
      errors++;
      $display("FAIL pri_key_start: got %h want %h", obs, vec(0, 0, 0, 2, 16'h0012));
    end
    idle();
    tick(1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== vec(1, 1, 1, 2, 16'h0012)) begin
      errors++;
      $display("FAIL pri_run_ignore: got %h want %h", obs, vec(1, 1, 1, 2, 16'h0012));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    key(4'd0);
    key(4'd0);
    start();
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL pri_empty_start: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
    key(4'd5);
    tick(1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL pri_cancel: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
  endtask

  task automatic test_clear_mid();
    key(4'd4);
    key(4'd2);
    tick(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL clr_entry: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
    key(4'd5);
    start();
    idle();
    tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== vec(1, 0, 0, 0, 16'h0000)) begin
      errors++;
      $display("FAIL clr_run: got %h want %h", obs, vec(1, 0, 0, 0, 16'h0000));
    end
  endtask

  task automatic test_random();
    logic c, kv, sk, ck, tz;
    logic [3:0] kc;
    tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      c  = ($urandom_range(99) == 0);
      kv = ($urandom_range(2) == 0);
      kc = 4'($urandom_range(15));
      sk = ($urandom_range(9) == 0);
      ck = ($urandom_range(24) == 0);
      tz = ($urandom_range(6) == 0);
      tick(c, kv, kc, sk, ck, tz);
      checks++;
      if (obs !== m_expect()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, m_expect());
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry_load();
    test_normalise();
    test_quick_start();
    test_saturate();
    test_cancel_zero();
    test_priority();
    test_clear_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
